// File: rtl/rsa_dma_pkg.sv
// Shared types and constants for the rsa DMA responder.
//   state_t     : responder FSM states
//   BEATS       : bus beats per block at the default widths
//   BEAT_IDX_W  : beat index width for the default widths
//   BYTE_STRIDE : byte increment between consecutive beats
package rsa_dma_pkg;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam int DATA_W_DEF  = 1024;
  localparam int BUS_W_DEF   = 32;
  localparam int TIMEOUT_DEF = 1023;
  localparam int BEATS       = DATA_W_DEF / BUS_W_DEF;
  localparam int BEAT_IDX_W  = $clog2(BEATS);

  localparam logic [31:0] BYTE_STRIDE = 32'd4;

  function automatic int beat_count(input int data_w, input int bus_w);
    return data_w / bus_w;
  endfunction

endpackage

// File: rtl/rsa_dma_responder_if.sv
// Memory-side beat bus of the rsa DMA responder.
//   mem_req/mem_we/mem_addr/mem_wdata : beat request (responder -> memory)
//   mem_ack/mem_rdata/mem_err         : beat completion (memory -> responder)
// master: the responder; slave: the memory bridge.
interface rsa_dma_responder_if
  import rsa_dma_pkg::*;
#(
  parameter int BUS_W = BUS_W_DEF
);
  logic             mem_req;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [BUS_W-1:0] mem_wdata;
  logic             mem_ack;
  logic [BUS_W-1:0] mem_rdata;
  logic             mem_err;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata, mem_err
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata, mem_err
  );
endinterface

// File: rtl/rsa_dma_timeout.sv
// Per-beat ack watchdog.
//   clk, reset : clock, synchronous active-high reset
//   load       : a new beat request starts; reload the budget
//   en         : request pending without ack this cycle; count down
//   expired    : budget exhausted (count is zero)
// With load value TIMEOUT-1, expired is seen in the TIMEOUT-th waiting cycle.
module rsa_dma_timeout
  import rsa_dma_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(TIMEOUT - 1);
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/rsa_dma_responder.sv
// Responder end of the rsa accelerator's block DMA interface.
// Moves one DATA_W block per request between a BUS_W word-addressed memory
// port and the dma_rx_data / dma_tx_data buses, one beat outstanding.
//   clk, reset                      : clock, synchronous active-high reset
//   dma_rx_start / dma_tx_start     : read / write block request pulses
//   dma_rx_address / dma_tx_address : block byte addresses
//   dma_tx_data                     : block to write (snapshotted at start)
//   dma_rx_data                     : last successfully read block
//   dma_idle, dma_done, dma_error   : status (idle level, done pulse, sticky error)
//   mem                             : memory beat bus (master side)
module rsa_dma_responder
  import rsa_dma_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int BUS_W   = BUS_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dma_rx_start,
  input  logic              dma_tx_start,
  input  logic [31:0]       dma_rx_address,
  input  logic [31:0]       dma_tx_address,
  input  logic [DATA_W-1:0] dma_tx_data,
  output logic [DATA_W-1:0] dma_rx_data,
  output logic              dma_idle,
  output logic              dma_done,
  output logic              dma_error,
  rsa_dma_responder_if.master mem
);
  localparam int NB = beat_count(DATA_W, BUS_W);
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  state_t            state, state_nx;
  logic [IW-1:0]     beat, beat_next;
  logic              bad_addr;
  logic [DATA_W-1:0] tx_block, rx_shadow, rx_merged;
  logic [31:0]       start_addr;
  logic              accept_rx, accept_tx, abort, finish;
  logic              beat_ok, beat_err, last_beat, expired;

  assign beat_ok    = mem.mem_req & mem.mem_ack & ~mem.mem_err;
  assign beat_err   = mem.mem_req & mem.mem_ack & mem.mem_err;
  assign last_beat  = (beat == IW'(NB - 1));
  assign beat_next  = beat + 1'b1;
  assign start_addr = accept_rx ? dma_rx_address : dma_tx_address;

  assign dma_idle = (state == IDLE);
  assign dma_done = (state == DONE);

  rsa_dma_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .load   (accept_rx | accept_tx | (beat_ok & ~last_beat)),
    .en     (mem.mem_req & ~mem.mem_ack),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // A misaligned start still enters READ/WRITE for one cycle, but with
  // mem_req never raised, so the error surfaces two cycles after the pulse.
  always_comb begin
    state_nx  = state;
    accept_rx = 1'b0;
    accept_tx = 1'b0;
    abort     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (dma_rx_start) begin
          accept_rx = 1'b1;
          state_nx  = READ;
        end else if (dma_tx_start) begin
          accept_tx = 1'b1;
          state_nx  = WRITE;
        end
      end
      READ, WRITE: begin
        if (bad_addr || beat_err || (mem.mem_req && !mem.mem_ack && expired)) begin
          abort    = 1'b1;
          state_nx = DONE;
        end else if (beat_ok && last_beat) begin
          finish   = 1'b1;
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Shadow buffer with the word being acked this cycle merged in; lets the
  // final beat publish the whole block in the same edge it is accepted.
  always_comb begin
    rx_merged = rx_shadow;
    rx_merged[beat*BUS_W +: BUS_W] = mem.mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      dma_rx_data   <= '0;
      dma_error     <= 1'b0;
      beat          <= '0;
      bad_addr      <= 1'b0;
      tx_block      <= '0;
      rx_shadow     <= '0;
    end else begin
      if (accept_rx || accept_tx) begin
        beat         <= '0;
        dma_error    <= 1'b0;
        bad_addr     <= (start_addr[1:0] != 2'b00);
        mem.mem_req  <= (start_addr[1:0] == 2'b00);
        mem.mem_we   <= accept_tx;
        mem.mem_addr <= start_addr;
        if (accept_tx) begin
          tx_block      <= dma_tx_data;
          mem.mem_wdata <= dma_tx_data[BUS_W-1:0];
        end
      end
      if (beat_ok) begin
        if (state == READ) rx_shadow <= rx_merged;
        if (!last_beat) begin
          beat         <= beat_next;
          mem.mem_addr <= mem.mem_addr + BYTE_STRIDE;
          if (state == WRITE) mem.mem_wdata <= tx_block[beat_next*BUS_W +: BUS_W];
        end
      end
      if (finish) begin
        mem.mem_req <= 1'b0;
        if (state == READ) dma_rx_data <= rx_merged;
      end
      if (abort) begin
        mem.mem_req <= 1'b0;
        dma_error   <= 1'b1;
      end
    end
  end
endmodule

// File: doc/rsa_dma_responder.md
Name: rsa_dma_responder

Overview:
Responder end of the accelerator's 1024-bit DMA interface. It accepts single-cycle dma_rx_start/dma_tx_start pulses from the rsa core and reports progress on dma_idle, dma_done and dma_error. Each transfer moves one block between a 32-bit word-addressed memory port and the 1024-bit dma_rx_data/dma_tx_data buses. It sits between the rsa core and the system memory bridge.

Parameters:
DATA_W, 1024, block width in bits.
BUS_W, 32, memory word width in bits; DATA_W must be a multiple of BUS_W.
TIMEOUT, 1023, maximum cycles to wait for mem_ack on one beat before aborting.

Ports:
clk  in  1  single clock.
reset  in  1  synchronous, active-high.
dma_rx_start  in  1  read-block request pulse; sampled only in IDLE.
dma_tx_start  in  1  write-block request pulse; sampled only in IDLE.
dma_rx_address  in  32  byte address of the read block.
dma_tx_address  in  32  byte address of the write block.
dma_tx_data  in  DATA_W  block to write.
dma_rx_data  out  DATA_W  last successfully read block.
dma_idle  out  1  high only in IDLE.
dma_done  out  1  one-cycle pulse at the end of a transfer, whether ok or error.
dma_error  out  1  sticky status of the last transfer.
mem_req  out  1  beat request; held until mem_ack.
mem_we  out  1  1 for a write beat, 0 for a read beat.
mem_addr  out  32  beat byte address.
mem_wdata  out  BUS_W  write word.
mem_ack  in  1  beat complete; mem_rdata is valid in the same cycle.
mem_rdata  in  BUS_W  read word.
mem_err  in  1  qualified by mem_ack; the beat failed.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state IDLE, dma_idle=1, dma_done=0, dma_error=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, dma_rx_data=0.
- Reset mid-transfer: the block returns to IDLE the next cycle and drops mem_req. It does not wait for mem_ack. dma_rx_data is cleared.
- FSM states:
  - IDLE: go to READ on rx_start, else go to WRITE on tx_start.
  - Misaligned start (addr[1:0]!=0): go straight to DONE with the error flag set. No bus traffic.
  - Both starts asserted together: rx wins and tx is dropped silently.
  - Starts arriving outside IDLE are ignored.
- Start acceptance:
  - Address is captured on the accepting cycle.
  - For tx, dma_tx_data is also snapshotted into the shift register on that cycle.
  - dma_idle falls in the cycle after the start pulse.
- READ and WRITE:
  - BEATS = DATA_W/BUS_W (32). Beat i uses mem_addr = base + 4*i. Beats are issued in order i = 0..BEATS-1 with one outstanding at a time.
  - Word i maps to bits [BUS_W*i +: BUS_W] (little-endian).
  - mem_req rises in the first cycle of READ/WRITE. It stays high with stable addr/we/wdata until mem_ack.
  - After an ack, the next beat's request is presented in the following cycle. Minimum cost is 2 cycles per beat.
  - Read words go into a shadow buffer. dma_rx_data is updated atomically from the shadow buffer only when the final beat acks without error.
- Abort conditions: a beat acked with mem_err=1, or TIMEOUT cycles without mem_ack.
  - On abort, drop mem_req and go to DONE with the error flag set.
  - dma_rx_data stays unchanged.
- DONE lasts exactly one cycle:
  - dma_done=1 and dma_error takes the transfer result.
  - Then return to IDLE.
- dma_error holds its value until the next accepted start, then clears.
- Latency with a zero-wait memory (ack in the cycle after req): start at cycle 0, READ at cycle 1, dma_done at cycle 1+2*BEATS = 65.

Decomposition:
- Package rsa_dma_pkg holds:
  - state enum {IDLE, READ, WRITE, DONE}
  - BEATS, and the beat index width clog2(BEATS)
  - the byte-stride constant 4
- Sub-module rsa_dma_timeout: a resettable down-counter that reloads on each new request and flags expiry at 0. The FSM, beat counter, shift register and shadow buffer stay in the top level.

Test Plan:
- Read, zero-wait memory where word i = 0xA000_0000+i, rx_addr=0x1000 → addresses 0x1000..0x107C in order, dma_done at cycle 65, dma_rx_data[31:0]=0xA0000000, [1023:992]=0xA000001F, dma_error=0.
- Write, tx_addr=0x2000, tx_data = {32{0xDEADBEEF}} with bits[31:0]=0x12345678; change dma_tx_data the cycle after start → 32 writes, first mem_wdata=0x12345678, all later words 0xDEADBEEF (snapshot honoured), dma_done at 65.
- Error on read beat 5 via mem_err=1 → mem_req drops, dma_done with dma_error=1, dma_rx_data equals the previous block; the next start clears dma_error.
- Misaligned rx_addr=0x1002 → no mem_req, dma_done two cycles after start, dma_error=1; timeout test: hold mem_ack=0 → abort after TIMEOUT cycles with dma_error=1.
- rx_start and tx_start in the same cycle, then a second start while busy → only one read occurs, no writes, one dma_done pulse.
- reset asserted at beat 10 of a read with a stalled ack → next cycle dma_idle=1, mem_req=0, dma_rx_data=0; a fresh read then completes normally.
